fir_pwm_out: RTL and testbench
==============================

Name: fir_pwm_out

Overview:
- Downstream output stage of fir_n: consumes y_out at the sample rate set by clk_divider's clk_d and drives a single-bit PWM audio DAC pin.
- Scales y_out by arithmetic shift, saturates to PWM_BITS, converts to an offset-binary duty cycle and generates glitch-free PWM.
- A mute state machine ramps the duty to midscale on ena fall (pop suppression) and ramps back in on ena rise.

Parameters:
- N, 32, width of y_in (signed two's complement, matches fir_n N).
- SHIFT, 8, arithmetic right shift applied to y_in before saturation.
- PWM_BITS, 8, PWM resolution; period = 2^PWM_BITS clk cycles.

Ports:
- clk  in  1  system clock (12 MHz).
- rst  in  1  synchronous, active-high reset.
- clk_d  in  1  sample-rate signal from clk_divider; its rising edge is detected in the clk domain.
- ena  in  1  1 = play, 0 = ramp to mute.
- y_in  in  N  filtered sample (fir_n y_out), signed.
- pwm_out  out  1  PWM output, registered.
- duty  out  PWM_BITS  duty currently applied (duty_active).
- clip  out  1  one-cycle pulse when a captured sample saturated.
- muted  out  1  high in MUTED state.

Behaviour:
- Reset values: pwm_out=0, duty=MID=2^(PWM_BITS-1), clip=0, muted=1, cnt=0, pending=MID, state=MUTED, clk_d_q=0.
- Edge detect: clk_d_q <= clk_d; stb = clk_d & ~clk_d_q. There is no output while rst=1.
- Pipeline:
  - Cycle t (stb=1): y_in captured.
  - t+1: s = y_in >>> SHIFT (sign-preserving).
  - t+2: sat = clamp(s, -2^(PWM_BITS-1), 2^(PWM_BITS-1)-1); pending <= sat + MID (offset binary); clip pulses at t+2 iff clamped.
  - A new stb overwrites any unused pending value; only the latest sample is kept.
- PWM counter: cnt increments every clk and wraps from 2^PWM_BITS-1 to 0. pwm_out <= (cnt < duty_active). duty 0 = always low; duty 255 = high 255/256.
- duty_active is updated only at period start (cnt wrap to 0). The sample period (~250 clk) and PWM period (256 clk) are asynchronous; the latest pending value wins.
- FSM, evaluated at each period start:
  - MUTED: duty_active=MID. If ena=1, go to RAMP_UP.
  - RAMP_UP: duty_active steps 1 LSB toward pending. Go to RUN when duty_active==pending or after 2^PWM_BITS periods in RAMP_UP. If ena=0, go to RAMP_DOWN.
  - RUN: duty_active=pending. If ena=0, go to RAMP_DOWN.
  - RAMP_DOWN: duty_active steps 1 LSB toward MID. At MID go to MUTED. If ena=1, go to RAMP_UP.
- The pipeline and pending keep updating in all states.
- Simultaneous events: stb on the same cycle as a period start means duty_active uses the old pending; the new sample applies next period.
- Reset mid-period: all state is restored to reset values the next clk.

Optional Feature:
- FIR_PWM_CLIP_CNT_EN defined: adds output clip_count [15:0], which increments on each clip pulse, saturates at 16'hFFFF and is cleared by rst.
- Undefined: the port and its counter are absent.

Decomposition:
- Package fir_pwm_pkg holds:
  - typedef state_t {MUTED, RAMP_UP, RUN, RAMP_DOWN};
  - function sat_to_offset(s) for clamp plus MID offset;
  - constant RAMP_TIMEOUT.
- One sub-module, pwm_gen (counter, period-start strobe, compare), instantiated once. The FSM and sample pipeline stay in the top module.

Test Plan:
- Reset release, ena=0: muted=1, duty=128, pwm_out high exactly 128 of every 256 clks.
- ena=1, impulse y_in=404 (101*4) on one clk_d edge then 0: pending=129 at t+2; duty 129 applied at next period start; no clip.
- y_in=100000: s=390, saturates to 127, duty=255, one-cycle clip. y_in=-100000 gives duty=0, pwm_out constantly 0, clip pulse.
- RUN at duty 200, ena falls: duty steps 199,198,… one per period, reaching 128 after 72 periods, then muted=1. Raising ena mid-ramp returns the FSM to RAMP_UP.
- Assert rst for 1 clk mid-RUN at duty 255: next cycle pwm_out=0, duty=128, state MUTED, cnt=0.
- With FIR_PWM_CLIP_CNT_EN: 3 clipping samples give clip_count=3; forcing 65540 clips leaves clip_count at 16'hFFFF.

Source files
------------

// File: rtl/fir_pwm_pkg.sv
// Shared types and helpers for the fir_pwm_out PWM audio output stage.
package fir_pwm_pkg;

   typedef enum logic [1:0] {MUTED, RAMP_UP, RUN, RAMP_DOWN} state_t;

   // Periods allowed in RAMP_UP before RUN is forced (2^PWM_BITS at PWM_BITS = 8).
   localparam int unsigned RAMP_TIMEOUT = 256;

   // Clamp s to a signed 'bits'-wide range, then re-bias to offset binary.
   function automatic logic [15:0] sat_to_offset(input logic signed [63:0] s,
                                                 input int unsigned bits);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      logic signed [63:0] v;
      hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (bits - 1));
      v  = s;
      if (s > hi) begin
         v = hi;
      end else if (s < lo) begin
         v = lo;
      end
      v = v + (64'sd1 <<< (bits - 1));
      return v[15:0];
   endfunction

   // True when sat_to_offset would have to clamp s.
   function automatic logic is_clipped(input logic signed [63:0] s, input int unsigned bits);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (bits - 1));
      return (s > hi) || (s < lo);
   endfunction

endpackage

// File: rtl/fir_pwm_out_pwm_gen.sv
// PWM counter, period-start strobe and registered compare for fir_pwm_out.
module pwm_gen #(
   parameter int unsigned PWM_BITS = 8
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [PWM_BITS-1:0] i_duty,
   output logic                o_pwm_out,
   output logic                o_period_start
);

   logic [PWM_BITS-1:0] r_cnt;

   // High in the last cycle of a period; the counter wraps to 0 on the next edge.
   assign o_period_start = (r_cnt == '1);

   // Free-running counter and compare; output is registered to stay glitch-free.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt     <= '0;
         o_pwm_out <= 1'b0;
      end else begin
         r_cnt     <= r_cnt + PWM_BITS'(1);
         o_pwm_out <= (r_cnt < i_duty);
      end
   end

endmodule

// File: rtl/fir_pwm_out.sv
// fir_pwm_out: scales fir_n samples into an offset-binary PWM duty with pop-free mute ramps.
// Optional macro FIR_PWM_CLIP_CNT_EN adds a saturating 16-bit clip counter output.
module fir_pwm_out
   import fir_pwm_pkg::*;
#(
   parameter int unsigned N        = 32,
   parameter int unsigned SHIFT    = 8,
   parameter int unsigned PWM_BITS = 8
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_clk_d,
   input  logic                i_ena,
   input  logic [N-1:0]        i_y_in,
   output logic                o_pwm_out,
   output logic [PWM_BITS-1:0] o_duty,
   output logic                o_clip,
`ifdef FIR_PWM_CLIP_CNT_EN
   output logic [15:0]         o_clip_count,
`endif
   output logic                o_muted
);

   localparam logic [PWM_BITS-1:0] MID = {1'b1, {(PWM_BITS-1){1'b0}}};
   localparam int unsigned         RCW = $clog2(RAMP_TIMEOUT) + 1;

   logic                r_clk_d_q;
   logic                w_stb;
   logic signed [N-1:0] r_y;
   logic signed [N-1:0] r_s;
   logic signed [63:0]  w_s_ext;
   logic                r_v1;
   logic                r_v2;
   logic [PWM_BITS-1:0] r_pending;
   logic                r_clip;

   state_t              r_state;
   state_t              w_state_d;
   logic [PWM_BITS-1:0] r_duty;
   logic [PWM_BITS-1:0] w_duty_d;
   logic [RCW-1:0]      r_ramp_cnt;
   logic [RCW-1:0]      w_ramp_cnt_d;
   logic [PWM_BITS-1:0] w_to_pend;
   logic [PWM_BITS-1:0] w_to_mid;
   logic                w_period_start;

   assign w_stb   = i_clk_d & ~r_clk_d_q;
   assign w_s_ext = {{(64-N){r_s[N-1]}}, r_s};

   // Sample pipeline: capture, shift, then saturate into pending; only the latest sample is kept.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_clk_d_q <= 1'b0;
         r_y       <= '0;
         r_s       <= '0;
         r_v1      <= 1'b0;
         r_v2      <= 1'b0;
         r_pending <= MID;
         r_clip    <= 1'b0;
      end else begin
         r_clk_d_q <= i_clk_d;
         if (w_stb) begin
            r_y <= i_y_in;
         end
         r_v1   <= w_stb;
         r_s    <= r_y >>> SHIFT;
         r_v2   <= r_v1;
         r_clip <= r_v2 & is_clipped(w_s_ext, PWM_BITS);
         if (r_v2) begin
            r_pending <= PWM_BITS'(sat_to_offset(w_s_ext, PWM_BITS));
         end
      end
   end

   // FSM state, applied duty and ramp timeout counter.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= MUTED;
         r_duty     <= MID;
         r_ramp_cnt <= '0;
      end else begin
         r_state    <= w_state_d;
         r_duty     <= w_duty_d;
         r_ramp_cnt <= w_ramp_cnt_d;
      end
   end

   // Next-state logic, evaluated only at PWM period start so duty never changes mid-period.
   always_comb begin
      w_state_d    = r_state;
      w_duty_d     = r_duty;
      w_ramp_cnt_d = r_ramp_cnt;
      w_to_pend    = r_duty;
      w_to_mid     = r_duty;
      if (r_duty < r_pending) begin
         w_to_pend = r_duty + PWM_BITS'(1);
      end else if (r_duty > r_pending) begin
         w_to_pend = r_duty - PWM_BITS'(1);
      end
      if (r_duty < MID) begin
         w_to_mid = r_duty + PWM_BITS'(1);
      end else if (r_duty > MID) begin
         w_to_mid = r_duty - PWM_BITS'(1);
      end
      if (w_period_start) begin
         unique case (r_state)
            MUTED: begin
               w_duty_d = MID;
               if (i_ena) begin
                  w_state_d    = RAMP_UP;
                  w_ramp_cnt_d = '0;
               end
            end
            RAMP_UP: begin
               if (!i_ena) begin
                  w_duty_d  = w_to_mid;
                  w_state_d = (w_to_mid == MID) ? MUTED : RAMP_DOWN;
               end else begin
                  w_duty_d     = w_to_pend;
                  w_ramp_cnt_d = r_ramp_cnt + RCW'(1);
                  if ((w_to_pend == r_pending) || (r_ramp_cnt == RCW'(RAMP_TIMEOUT - 1))) begin
                     w_state_d = RUN;
                  end
               end
            end
            RUN: begin
               if (!i_ena) begin
                  w_duty_d  = w_to_mid;
                  w_state_d = (w_to_mid == MID) ? MUTED : RAMP_DOWN;
               end else begin
                  w_duty_d = r_pending;
               end
            end
            RAMP_DOWN: begin
               if (i_ena) begin
                  w_duty_d     = w_to_pend;
                  w_state_d    = RAMP_UP;
                  w_ramp_cnt_d = '0;
               end else begin
                  w_duty_d = w_to_mid;
                  if (w_to_mid == MID) begin
                     w_state_d = MUTED;
                  end
               end
            end
            default: begin
               w_state_d = MUTED;
               w_duty_d  = MID;
            end
         endcase
      end
   end

`ifdef FIR_PWM_CLIP_CNT_EN
   logic [15:0] r_clip_count;

   // Saturating count of clip pulses.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_clip_count <= '0;
      end else if (r_clip && (r_clip_count != 16'hFFFF)) begin
         r_clip_count <= r_clip_count + 16'd1;
      end
   end

   assign o_clip_count = r_clip_count;
`endif

   pwm_gen #(
      .PWM_BITS(PWM_BITS)
   ) u_pwm_gen (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_duty        (r_duty),
      .o_pwm_out     (o_pwm_out),
      .o_period_start(w_period_start)
   );

   assign o_duty  = r_duty;
   assign o_clip  = r_clip;
   assign o_muted = (r_state == MUTED);

endmodule

// File: tb/tb_fir_pwm_out.sv
// Directed self-checking bench for fir_pwm_out.
module tb_fir_pwm_out;
   import fir_pwm_pkg::*;

   logic        clk;
   logic        rst;
   logic        clk_d;
   logic        ena;
   logic [31:0] y;
   logic        pwm;
   logic [7:0]  duty;
   logic        clip;
   logic        muted;
`ifdef FIR_PWM_CLIP_CNT_EN
   logic [15:0] clip_count;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   fir_pwm_out #(
      .N       (32),
      .SHIFT   (8),
      .PWM_BITS(8)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_clk_d     (clk_d),
      .i_ena       (ena),
      .i_y_in      (y),
      .o_pwm_out   (pwm),
      .o_duty      (duty),
      .o_clip      (clip),
`ifdef FIR_PWM_CLIP_CNT_EN
      .o_clip_count(clip_count),
`endif
      .o_muted     (muted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Return #1 after the edge where the PWM counter wraps to 0 (new duty applied).
   task automatic next_period();
      int n;
      n = 0;
      @(negedge clk);
      while ((dut.u_pwm_gen.r_cnt != 8'hFF) && (n < 300)) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         check_val("period_start_timeout", 32'(n), 32'd0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic count_high(input int cycles, output int highs);
      highs = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (pwm === 1'b1) highs++;
      end
   endtask

   // One clk_d rising edge carrying yv; checks clip timing and the resulting pending value.
   task automatic send_sample(input logic [31:0] yv, input logic exp_clip, input int exp_pend);
      @(negedge clk);
      y     = yv;
      clk_d = 1'b1;
      @(negedge clk);
      check_val("clip_t0", 32'(clip), 32'd0);
      @(negedge clk);
      @(negedge clk);
      check_val("clip_t2", 32'(clip), 32'(exp_clip));
      check_val("pending_t2", 32'(dut.r_pending), 32'(exp_pend));
      @(negedge clk);
      check_val("clip_one_cycle", 32'(clip), 32'd0);
      clk_d = 1'b0;
   endtask

   initial begin
      int highs;
      rst   = 1'b1;
      ena   = 1'b0;
      clk_d = 1'b0;
      y     = '0;
      repeat (3) @(negedge clk);
      check_val("rst_pwm", 32'(pwm), 32'd0);
      check_val("rst_duty", 32'(duty), 32'd128);
      check_val("rst_clip", 32'(clip), 32'd0);
      check_val("rst_muted", 32'(muted), 32'd1);
      check_val("rst_cnt", 32'(dut.u_pwm_gen.r_cnt), 32'd0);
      rst = 1'b0;

      // Muted: 50% duty.
      next_period();
      count_high(256, highs);
      check_val("muted_high_count_a", 32'(highs), 32'd128);
      count_high(256, highs);
      check_val("muted_high_count_b", 32'(highs), 32'd128);
      check_val("muted_flag", 32'(muted), 32'd1);

      // Ramp in to a small impulse.
      next_period();
      ena = 1'b1;
      send_sample(32'd404, 1'b0, 129);
      next_period();
      check_val("rampup_duty", 32'(duty), 32'd128);
      check_val("rampup_state", 32'(dut.r_state), 32'(RAMP_UP));
      check_val("rampup_muted", 32'(muted), 32'd0);
      next_period();
      check_val("run_duty_129", 32'(duty), 32'd129);
      check_val("run_state", 32'(dut.r_state), 32'(RUN));
      count_high(256, highs);
      check_val("high_count_129", 32'(highs), 32'd129);
      send_sample(32'd0, 1'b0, 128);
      next_period();
      check_val("run_duty_128", 32'(duty), 32'd128);

      // Positive and negative saturation.
      send_sample(32'd100000, 1'b1, 255);
      next_period();
      check_val("sat_pos_duty", 32'(duty), 32'd255);
      count_high(256, highs);
      check_val("high_count_255", 32'(highs), 32'd255);
      send_sample(-32'sd100000, 1'b1, 0);
      next_period();
      check_val("sat_neg_duty", 32'(duty), 32'd0);
      count_high(256, highs);
      check_val("high_count_0", 32'(highs), 32'd0);
`ifdef FIR_PWM_CLIP_CNT_EN
      check_val("clip_count_2", 32'(clip_count), 32'd2);
`endif

      // Ramp down from 200 to mute.
      send_sample(32'd18432, 1'b0, 200);
      next_period();
      check_val("run_duty_200", 32'(duty), 32'd200);
      ena = 1'b0;
      for (int k = 1; k <= 72; k++) begin
         next_period();
         check_val("rampdown_duty", 32'(duty), 32'(200 - k));
         check_val("rampdown_muted", 32'(muted), 32'(k == 72));
      end

      // Ramp back in, interrupt it, resume.
      ena = 1'b1;
      next_period();
      check_val("reup_duty", 32'(duty), 32'd128);
      for (int k = 1; k <= 4; k++) begin
         next_period();
         check_val("reup_step", 32'(duty), 32'(128 + k));
      end
      ena = 1'b0;
      next_period();
      check_val("interrupt_duty", 32'(duty), 32'd131);
      check_val("interrupt_state", 32'(dut.r_state), 32'(RAMP_DOWN));
      ena = 1'b1;
      next_period();
      check_val("resume_duty", 32'(duty), 32'd132);
      check_val("resume_state", 32'(dut.r_state), 32'(RAMP_UP));
      send_sample(32'd1280, 1'b0, 133);
      next_period();
      check_val("reach_duty", 32'(duty), 32'd133);
      check_val("reach_state", 32'(dut.r_state), 32'(RUN));

      // Reset mid-period while running at full duty.
      send_sample(32'd100000, 1'b1, 255);
      next_period();
      check_val("pre_rst_duty", 32'(duty), 32'd255);
      repeat (50) @(negedge clk);
      check_val("pre_rst_pwm", 32'(pwm), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_val("midrst_pwm", 32'(pwm), 32'd0);
      check_val("midrst_duty", 32'(duty), 32'd128);
      check_val("midrst_muted", 32'(muted), 32'd1);
      check_val("midrst_state", 32'(dut.r_state), 32'(MUTED));
      check_val("midrst_cnt", 32'(dut.u_pwm_gen.r_cnt), 32'd0);
      check_val("midrst_pending", 32'(dut.r_pending), 32'd128);
`ifdef FIR_PWM_CLIP_CNT_EN
      check_val("midrst_clip_count", 32'(clip_count), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
